// File: rtl/data_memory_responder.sv
// data_memory_responder
//   Responder side of the CPU load/store data port. A DEPTH x 32-bit RAM sits
//   behind a valid/ready request channel and a valid/ready response channel.
//   The response appears a fixed LATENCY cycles after the request is accepted.
//   The array is read and conditionally written on the edge that enters RESP,
//   so a store returns the word's old contents (read-before-write).
//
// Parameters
//   DEPTH   : number of 32-bit words; word index = req_addr[31:2]
//   LATENCY : acceptance edge to rsp_valid, 1..15 cycles
//
// Ports
//   clk          : clock, rising edge
//   reset        : asynchronous, active-low reset
//   req_valid    : request present
//   req_ready    : responder can accept a request (IDLE and no init_load)
//   req_write    : 1 = store, 0 = load
//   req_addr     : byte address
//   req_wdata    : store data
//   req_wstrb    : byte enables, bit i covers bits [8i+7:8i]
//   rsp_valid    : response present
//   rsp_ready    : requester accepts the response
//   rsp_rdata    : load data / old word for stores / 0 on error
//   rsp_error    : misaligned or out-of-range access
//   init_load    : copy init_values into the array (honoured in IDLE only)
//   init_values  : bulk-load image, word k at [k]
//   memory_check : continuous view of the array contents
module data_memory_responder #(
  parameter int DEPTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [3:0]            req_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_error,
  input  logic                  init_load,
  input  logic [DEPTH-1:0][31:0] init_values,
  output logic [DEPTH-1:0][31:0] memory_check
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // WAIT spends LATENCY-1 edges before entering RESP; the edge with cnt == 0
  // is itself the entry edge, hence the -2.
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  state_t                  state;
  logic [3:0]              cnt;
  logic [DEPTH-1:0][31:0]  mem;

  logic                    lat_write;
  logic [31:0]             lat_addr;
  logic [31:0]             lat_wdata;
  logic [3:0]              lat_wstrb;

  logic                    accept;
  logic                    enter_resp;
  logic                    e_write;
  logic [31:0]             e_addr;
  logic [31:0]             e_wdata;
  logic [3:0]              e_wstrb;
  logic                    e_err;
  logic [IDX_W-1:0]        e_idx;

  function automatic logic addr_error(input logic [31:0] a);
    // No aliasing: any word index beyond the array is rejected outright.
    return (a[1:0] != 2'b00) || (32'(a[31:2]) >= 32'(DEPTH));
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

  assign memory_check = mem;

  always_comb begin
    req_ready  = (state == IDLE) && !init_load;
    accept     = req_valid && req_ready;
    // With LATENCY == 1 the acceptance edge is also the RESP-entry edge, so
    // the access must use the live request instead of the latched copy.
    enter_resp = ((state == IDLE) && accept && (LATENCY == 1)) ||
                 ((state == WAIT) && (cnt == 4'd0));
    if (state == IDLE) begin
      e_write = req_write;
      e_addr  = req_addr;
      e_wdata = req_wdata;
      e_wstrb = req_wstrb;
    end else begin
      e_write = lat_write;
      e_addr  = lat_addr;
      e_wdata = lat_wdata;
      e_wstrb = lat_wstrb;
    end
    e_err = addr_error(e_addr);
    e_idx = e_addr[2 +: IDX_W];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_error <= 1'b0;
      mem       <= '0;
      lat_write <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      lat_wstrb <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (init_load) begin
            mem <= init_values;
          end else if (accept) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_wstrb <= req_wstrb;
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else             state <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // ---- RESP entry: check, read old word, apply strobed store ----
      if (enter_resp) begin
        rsp_valid <= 1'b1;
        if (e_err) begin
          rsp_error <= 1'b1;
          rsp_rdata <= 32'd0;
        end else begin
          rsp_error <= 1'b0;
          rsp_rdata <= mem[e_idx];
          if (e_write) mem[e_idx] <= merge_bytes(mem[e_idx], e_wdata, e_wstrb);
        end
      end
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
module tb_data_memory_responder;

  localparam int DEPTH = 32;
  localparam int LAT_A = 2;
  localparam int LAT_B = 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic                   a_req_valid, a_req_ready, a_req_write;
  logic [31:0]            a_req_addr, a_req_wdata;
  logic [3:0]             a_req_wstrb;
  logic                   a_rsp_valid, a_rsp_ready, a_rsp_error;
  logic [31:0]            a_rsp_rdata;
  logic                   a_init_load;
  logic [DEPTH-1:0][31:0] a_init_values, a_memory_check;

  logic                   b_req_valid, b_req_ready, b_req_write;
  logic [31:0]            b_req_addr, b_req_wdata;
  logic [3:0]             b_req_wstrb;
  logic                   b_rsp_valid, b_rsp_ready, b_rsp_error;
  logic [31:0]            b_rsp_rdata;
  logic                   b_init_load;
  logic [DEPTH-1:0][31:0] b_init_values, b_memory_check;

  data_memory_responder #(.DEPTH(DEPTH), .LATENCY(LAT_A)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_wstrb(a_req_wstrb),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
    .rsp_error(a_rsp_error), .init_load(a_init_load), .init_values(a_init_values),
    .memory_check(a_memory_check)
  );

  data_memory_responder #(.DEPTH(DEPTH), .LATENCY(LAT_B)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wstrb(b_req_wstrb),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
    .rsp_error(b_rsp_error), .init_load(b_init_load), .init_values(b_init_values),
    .memory_check(b_memory_check)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] ref_mem [DEPTH];

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          hold;
    logic [31:0] exp_rd;
    logic        exp_er;
  } vec_t;

  vec_t vt [13];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: one access applied to a plain word array.
  function automatic void model_access(input logic w, input logic [31:0] addr,
                                       input logic [31:0] wdata, input logic [3:0] strb,
                                       output logic [31:0] rdata, output logic err);
    logic [31:0] widx;
    widx = addr / 4;
    err  = (addr % 4 != 0) || (widx >= DEPTH);
    if (err) begin
      rdata = 32'd0;
    end else begin
      rdata = ref_mem[widx];
      if (w) begin
        for (int b = 0; b < 4; b++)
          if (strb[b]) ref_mem[widx][8*b +: 8] = wdata[8*b +: 8];
      end
    end
  endfunction

  task automatic txn_a(input string tag, input logic w, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb, input int hold,
                       input logic [31:0] exp_rd, input logic exp_er);
    int n;
    logic [31:0] held_rd;
    logic        held_er;
    n = 0;
    while (!a_req_ready && n < 20) begin step(); n++; end
    if (!a_req_ready) begin
      checks++; errors++;
      $display("FAIL %s_ready_timeout got=0 exp=1", tag);
      return;
    end
    a_req_valid = 1'b1; a_req_write = w; a_req_addr = addr;
    a_req_wdata = wdata; a_req_wstrb = strb;
    step();  // acceptance edge
    a_req_valid = 1'b0; a_req_write = $urandom_range(0, 1); a_req_addr = $urandom();
    a_req_wdata = $urandom(); a_req_wstrb = 4'($urandom());
    n = 1;
    while (!a_rsp_valid && n < 40) begin step(); n++; end
    chk({tag, "_latency"}, n, LAT_A);
    chk({tag, "_rdata"}, a_rsp_rdata, exp_rd);
    chk({tag, "_error"}, {31'd0, a_rsp_error}, {31'd0, exp_er});
    held_rd = a_rsp_rdata;
    held_er = a_rsp_error;
    if (hold > 0) begin
      a_req_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        chk({tag, "_hold_req_ready"}, {31'd0, a_req_ready}, 32'd0);
        step();
        chk({tag, "_hold_valid"}, {31'd0, a_rsp_valid}, 32'd1);
        chk({tag, "_hold_rdata"}, a_rsp_rdata, held_rd);
        chk({tag, "_hold_error"}, {31'd0, a_rsp_error}, {31'd0, held_er});
      end
      a_req_valid = 1'b0;
    end
    a_rsp_ready = 1'b1;
    step();  // handshake edge
    a_rsp_ready = 1'b0;
    chk({tag, "_valid_drop"}, {31'd0, a_rsp_valid}, 32'd0);
    chk({tag, "_ready_after"}, {31'd0, a_req_ready}, 32'd1);
  endtask

  task automatic compare_mem_a(input string tag);
    for (int k = 0; k < DEPTH; k++)
      chk($sformatf("%s_mem%0d", tag, k), a_memory_check[k], ref_mem[k]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] addr;
    logic [DEPTH-1:0][31:0] snap;
    int r;

    a_req_valid = 0; a_req_write = 0; a_req_addr = 0; a_req_wdata = 0; a_req_wstrb = 0;
    a_rsp_ready = 0; a_init_load = 0; a_init_values = '0;
    b_req_valid = 0; b_req_write = 0; b_req_addr = 0; b_req_wdata = 0; b_req_wstrb = 0;
    b_rsp_ready = 0; b_init_load = 0; b_init_values = '0;
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = 32'd0;

    // Directed vectors following an init image of 0x1000_0000+k.
    vt[0]  = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 5, 32'h1000_0002, 1'b0};
    vt[1]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 32'h1000_0004, 1'b0};
    vt[2]  = '{1'b1, 32'h0000_0010, 32'h0000_CAFE, 4'h3, 0, 32'hDEAD_BEEF, 1'b0};
    vt[3]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 1, 32'hDEAD_CAFE, 1'b0};
    vt[4]  = '{1'b0, 32'h0000_0006, 32'h0,         4'h0, 0, 32'h0,         1'b1};
    vt[5]  = '{1'b1, 32'h0000_0080, 32'hFFFF_FFFF, 4'hF, 2, 32'h0,         1'b1};
    vt[6]  = '{1'b1, 32'h0000_0014, 32'h0000_0055, 4'h0, 0, 32'h1000_0005, 1'b0};
    vt[7]  = '{1'b0, 32'h0000_0014, 32'h0,         4'h0, 0, 32'h1000_0005, 1'b0};
    vt[8]  = '{1'b0, 32'h0000_007C, 32'h0,         4'h0, 0, 32'h1000_001F, 1'b0};
    vt[9]  = '{1'b0, 32'h0000_0084, 32'h0,         4'h0, 0, 32'h0,         1'b1};
    vt[10] = '{1'b1, 32'h0000_007C, 32'hA5A5_A5A5, 4'h9, 0, 32'h1000_001F, 1'b0};
    vt[11] = '{1'b0, 32'h0000_007C, 32'h0,         4'h0, 0, 32'hA500_00A5, 1'b0};
    vt[12] = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 0, 32'h0,         1'b1};

    // ---- reset state ----
    step(); step();
    chk("rst_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", a_rsp_rdata, 32'd0);
    chk("rst_rsp_error", {31'd0, a_rsp_error}, 32'd0);
    chk("rst_req_ready", {31'd0, a_req_ready}, 32'd1);
    chk("rst_b_rsp_valid", {31'd0, b_rsp_valid}, 32'd0);
    compare_mem_a("rst");
    reset = 1'b1;
    step();

    // ---- bulk load ----
    for (int k = 0; k < DEPTH; k++) begin
      a_init_values[k] = 32'h1000_0000 + k;
      ref_mem[k] = 32'h1000_0000 + k;
    end
    a_init_load = 1'b1;
    #1;
    chk("init_req_ready_low", {31'd0, a_req_ready}, 32'd0);
    step();
    a_init_load = 1'b0;
    compare_mem_a("init");

    // ---- table ----
    for (int i = 0; i < 13; i++) begin
      model_access(vt[i].w, vt[i].addr, vt[i].wdata, vt[i].strb, rd, er);
      txn_a($sformatf("vec%0d", i), vt[i].w, vt[i].addr, vt[i].wdata, vt[i].strb,
            vt[i].hold, vt[i].exp_rd, vt[i].exp_er);
    end
    compare_mem_a("after_table");

    // ---- randomized traffic against the model ----
    for (int t = 0; t < 60; t++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       addr = 32'($urandom_range(0, DEPTH - 1)) * 4;
      else if (r == 7) addr = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
      else if (r == 8) addr = 32'($urandom_range(DEPTH, DEPTH + 40)) * 4;
      else             addr = $urandom();
      begin
        logic        w;
        logic [31:0] wd;
        logic [3:0]  st;
        w  = 1'($urandom_range(0, 1));
        wd = $urandom();
        st = 4'($urandom());
        model_access(w, addr, wd, st, rd, er);
        txn_a($sformatf("rnd%0d", t), w, addr, wd, st, $urandom_range(0, 3), rd, er);
      end
    end
    compare_mem_a("after_rnd");

    // ---- reset while a store waits ----
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 32'h4;
    a_req_wdata = 32'h1234_5678; a_req_wstrb = 4'hF;
    chk("rstwait_ready", {31'd0, a_req_ready}, 32'd1);
    step();  // accepted, now in WAIT
    a_req_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rstwait_valid", {31'd0, a_rsp_valid}, 32'd0);
    chk("rstwait_rdata", a_rsp_rdata, 32'd0);
    chk("rstwait_word1", a_memory_check[1], 32'd0);
    chk("rstwait_req_ready", {31'd0, a_req_ready}, 32'd1);
    step();
    reset = 1'b1;
    step(); step(); step();
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = 32'd0;
    chk("rstrel_valid", {31'd0, a_rsp_valid}, 32'd0);
    chk("rstrel_req_ready", {31'd0, a_req_ready}, 32'd1);
    compare_mem_a("rstrel");

    // ---- LATENCY = 1 instance ----
    for (int k = 0; k < DEPTH; k++) b_init_values[k] = 32'h2000_0000 + k;
    b_init_load = 1'b1;
    step();
    b_init_load = 1'b0;
    chk("b_init_word3", b_memory_check[3], 32'h2000_0003);
    b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 32'hC; b_req_wstrb = 4'hF;
    #1;
    chk("b_req_ready", {31'd0, b_req_ready}, 32'd1);
    step();  // acceptance edge T
    b_req_valid = 1'b0; b_req_addr = 32'h0;
    chk("b_lat1_valid", {31'd0, b_rsp_valid}, 32'd1);
    chk("b_lat1_rdata", b_rsp_rdata, 32'h2000_0003);
    chk("b_lat1_error", {31'd0, b_rsp_error}, 32'd0);
    snap = b_memory_check;
    for (int k = 0; k < DEPTH; k++) b_init_values[k] = 32'hFFFF_FFFF;
    b_init_load = 1'b1;
    step(); step();
    chk("b_resp_hold_valid", {31'd0, b_rsp_valid}, 32'd1);
    chk("b_resp_req_ready", {31'd0, b_req_ready}, 32'd0);
    b_init_load = 1'b0;
    b_rsp_ready = 1'b1;
    step();
    b_rsp_ready = 1'b0;
    chk("b_valid_drop", {31'd0, b_rsp_valid}, 32'd0);
    for (int k = 0; k < DEPTH; k++)
      chk($sformatf("b_init_ignored%0d", k), b_memory_check[k], snap[k]);
    b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 32'h0;
    b_req_wdata = 32'h1122_3344; b_req_wstrb = 4'hF;
    step();
    b_req_valid = 1'b0;
    chk("b_store_valid", {31'd0, b_rsp_valid}, 32'd1);
    chk("b_store_rdata", b_rsp_rdata, 32'h2000_0000);
    chk("b_store_word0", b_memory_check[0], 32'h1122_3344);
    b_rsp_ready = 1'b1;
    step();
    b_rsp_ready = 1'b0;
    chk("b_store_drop", {31'd0, b_rsp_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Responder end of the CPU's load/store data interface: a DEPTH-word, 32-bit data RAM behind a valid/ready request channel and a valid/ready response channel.
- Responds after a programmable latency. Supports byte strobes and flags misaligned or out-of-range accesses.
- Replaces the zero-latency combinational data memory once the core moves to a handshaked memory port.
- Also provides a synchronous bulk-load port and a debug view of the whole array.

Parameters:
- DEPTH, 32: number of 32-bit words; word index = req_addr[31:2].
- LATENCY, 2: cycles from request acceptance to rsp_valid; legal range 1..15.

Ports:
- clk, input, 1: clock; all state updates on rising edge.
- reset, input, 1: asynchronous, active-low reset.
- req_valid, input, 1: request present.
- req_ready, output, 1: responder can accept a request.
- req_write, input, 1: 1 = store, 0 = load.
- req_addr, input, 32: byte address.
- req_wdata, input, 32: store data.
- req_wstrb, input, 4: byte enables; bit i covers bits [8i+7:8i].
- rsp_valid, output, 1: response present.
- rsp_ready, input, 1: requester accepts the response.
- rsp_rdata, output, 32: load data (old word contents for stores; 0 on error).
- rsp_error, output, 1: misaligned or out-of-range access.
- init_load, input, 1: copy init_values into the array.
- init_values, input, 32 x DEPTH: bulk-load image.
- memory_check, output, 32 x DEPTH: continuous view of the array contents.

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE, latency counter = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_error = 0.
  - All array words = 0.
  - Any captured request is discarded, including a pending write.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = !init_load.
  - Acceptance = req_valid && req_ready. On acceptance, latch write, addr, wdata and wstrb.
  - If LATENCY == 1, go to RESP. Otherwise go to WAIT with counter = LATENCY-2.
- WAIT:
  - req_ready = 0.
  - While counter != 0, decrement it.
  - When counter == 0, go to RESP on that edge.
- RESP entry (the edge into RESP):
  - Error check: error = addr[1:0] != 0, or word index >= DEPTH.
  - On error: rsp_error = 1, rsp_rdata = 0, no array write.
  - On a legal access: rsp_rdata = current word (read-before-write), rsp_error = 0.
  - On a legal store: the same edge writes each byte i whose wstrb[i] = 1; other bytes keep their value.
  - wstrb = 0 on a store is a legal no-op, not an error. Loads ignore wstrb.
- Response timing: rsp_valid first high LATENCY cycles after the acceptance edge.
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_error stay stable until the handshake.
  - req_ready = 0.
  - On rsp_valid && rsp_ready: rsp_valid drops next cycle and state returns to IDLE.
  - No back-to-back acceptance: there is at least one IDLE cycle between responses.
- Outputs are registered. rsp_rdata and rsp_error are held after the handshake (don't-care while rsp_valid = 0).
- init_load:
  - Honoured only in IDLE. On that edge the whole array = init_values.
  - req_ready is low that cycle, so no request can collide with it.
  - Ignored in WAIT/RESP.
- memory_check is combinational from the array; it reflects a write the cycle after the RESP-entry edge.
- Address wrap: no wrap. Any index >= DEPTH is an error, even if the low bits would alias.

Test Plan:
- Reset, init_load with init_values[k] = 0x1000_0000+k; load 0x0000_0008 (LATENCY=2) -> rsp_valid exactly 2 cycles after acceptance, rsp_rdata = 0x1000_0002, rsp_error = 0.
- Store 0xDEADBEEF @0x10 wstrb=0xF; store 0x0000CAFE @0x10 wstrb=0x3; load @0x10 -> rsp_rdata 0xDEADCAFE. The second store's response returns 0xDEADBEEF (read-before-write).
- Load @0x6 -> rsp_error = 1, rsp_rdata = 0. Store @0x80 with DEPTH=32 -> rsp_error = 1, memory_check unchanged.
- Hold rsp_ready = 0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready = 0 throughout. A new req_valid is not accepted until one cycle after the handshake.
- Drive reset low in WAIT of a store 0x12345678 @0x4 -> rsp_valid = 0 immediately, word 1 = 0 after reset release, state IDLE, req_ready = 1.
- LATENCY=1 build: load accepted at edge T -> rsp_valid high in the cycle after T. init_load asserted while in RESP -> array unchanged.
